pixel_writeback: RTL



---
 rtl/pixel_wb_pkg.sv | 14 +
 rtl/pixel_writeback_if.sv | 27 ++
 rtl/pixel_lane_pick.sv | 18 +
 rtl/pixel_writeback.sv | 116 +++++++++++
 4 files changed

// File: rtl/pixel_wb_pkg.sv
// rtl/pixel_wb_pkg.sv - shared widths, lane constants and FSM state type for pixel_writeback
package pixel_wb_pkg;
  localparam int WB_BITS_ARRAY = 64;
  localparam int WB_BITS_PIXEL = 8;
  localparam int WB_ADDR_W     = 16;
  localparam int LANES         = WB_BITS_ARRAY / WB_BITS_PIXEL;
  localparam int LANE_W        = $clog2(LANES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_DONE
  } wb_state_t;
endpackage

// File: rtl/pixel_writeback_if.sv
// rtl/pixel_writeback_if.sv - result-vector handshake and pixel-memory write port bundle
interface pixel_writeback_if #(
  parameter int BITS_ARRAY = pixel_wb_pkg::WB_BITS_ARRAY,
  parameter int BITS_PIXEL = pixel_wb_pkg::WB_BITS_PIXEL,
  parameter int ADDR_W     = pixel_wb_pkg::WB_ADDR_W,
  parameter int LANES      = pixel_wb_pkg::LANES
);
  logic                  res_valid;
  logic                  res_ready;
  logic [BITS_ARRAY-1:0] res_data;
  logic [ADDR_W-1:0]     res_addr;
  logic [LANES-1:0]      res_mask;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [BITS_PIXEL-1:0] mem_wdata;
  logic                  mem_ack;

  modport slave (
    input  res_valid, res_data, res_addr, res_mask, mem_ack,
    output res_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output res_valid, res_data, res_addr, res_mask, mem_ack,
    input  res_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/pixel_lane_pick.sv
// rtl/pixel_lane_pick.sv - priority encoder: lowest set lane of a mask plus an any-left flag
module pixel_lane_pick
  import pixel_wb_pkg::*;
(
  input  logic [LANES-1:0]  mask,
  output logic [LANE_W-1:0] lane,
  output logic              any
);

  always_comb begin
    lane = '0;
    for (int k = LANES - 1; k >= 0; k--) begin
      if (mask[k]) lane = LANE_W'(k);
    end
    any = |mask;
  end

endmodule

// File: rtl/pixel_writeback.sv
// rtl/pixel_writeback.sv - serialises a masked 8-lane pixel vector into byte-wide memory writes
// Define PIXEL_WB_PINGPONG_EN to add a holding register that queues one vector behind the active one.
module pixel_writeback
  import pixel_wb_pkg::*;
#(
  parameter int BITS_ARRAY = WB_BITS_ARRAY,
  parameter int BITS_PIXEL = WB_BITS_PIXEL,
  parameter int ADDR_W     = WB_ADDR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  pixel_writeback_if.slave bus,
  output logic             busy,
  output logic             done
);

  wb_state_t             state, state_nx;
  logic [BITS_ARRAY-1:0] act_data, ld_data;
  logic [ADDR_W-1:0]     act_addr, ld_addr;
  logic [LANES-1:0]      remain, remain_after, ld_mask, pick_in;
  logic [LANE_W-1:0]     lane_q, pick_lane;
  logic                  pick_any, accept, load, ready_ok;

  assign accept       = bus.res_valid && bus.res_ready;
  assign remain_after = remain & ~(LANES'(1) << lane_q);
  // One encoder serves both a fresh load and the post-ack remainder; they never coincide.
  assign pick_in      = load ? ld_mask : remain_after;

  pixel_lane_pick u_pick (
    .mask (pick_in),
    .lane (pick_lane),
    .any  (pick_any)
  );

`ifdef PIXEL_WB_PINGPONG_EN
  logic                  hold_full;
  logic [BITS_ARRAY-1:0] hold_data;
  logic [ADDR_W-1:0]     hold_addr;
  logic [LANES-1:0]      hold_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_full <= 1'b0;
      hold_data <= '0;
      hold_addr <= '0;
      hold_mask <= '0;
    end else if (accept && state == ST_WRITE) begin
      hold_full <= 1'b1;
      hold_data <= bus.res_data;
      hold_addr <= bus.res_addr;
      hold_mask <= bus.res_mask;
    end else if (load && hold_full) begin
      hold_full <= 1'b0;
    end
  end

  assign ready_ok = !hold_full;
  assign load     = (state == ST_DONE && hold_full) || (accept && state != ST_WRITE);
  assign ld_data  = hold_full ? hold_data : bus.res_data;
  assign ld_addr  = hold_full ? hold_addr : bus.res_addr;
  assign ld_mask  = hold_full ? hold_mask : bus.res_mask;
`else
  assign ready_ok = (state == ST_IDLE);
  assign load     = accept;
  assign ld_data  = bus.res_data;
  assign ld_addr  = bus.res_addr;
  assign ld_mask  = bus.res_mask;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (load) state_nx = pick_any ? ST_WRITE : ST_DONE;
      ST_WRITE: if (bus.mem_ack) state_nx = pick_any ? ST_WRITE : ST_DONE;
      ST_DONE:  state_nx = load ? (pick_any ? ST_WRITE : ST_DONE) : ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    busy          = (state != ST_IDLE);
    done          = (state == ST_DONE);
    bus.res_ready = rst_n && ready_ok;
    bus.mem_we    = (state == ST_WRITE);
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (state == ST_WRITE) begin
      bus.mem_addr  = act_addr + ADDR_W'(lane_q);
      bus.mem_wdata = act_data[lane_q * BITS_PIXEL +: BITS_PIXEL];
    end
  end

  // lane_q always points at the lowest lane still pending in remain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_data <= '0;
      act_addr <= '0;
      remain   <= '0;
      lane_q   <= '0;
    end else if (load) begin
      act_data <= ld_data;
      act_addr <= ld_addr;
      remain   <= ld_mask;
      lane_q   <= pick_lane;
    end else if (state == ST_WRITE && bus.mem_ack) begin
      remain   <= remain_after;
      lane_q   <= pick_lane;
    end
  end

endmodule
